// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and defaults for the multdiv issue/writeback controller.
package multdiv_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned EXC_W  = 5;

  localparam int unsigned DEF_TIMEOUT    = 40;
  localparam int unsigned DEF_STATUS_REG = 30;
  localparam int unsigned DEF_MULT_EXC   = 4;
  localparam int unsigned DEF_DIV_EXC    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Captured identity of the in-flight operation.
  typedef struct packed {
    logic            is_div;
    logic [RD_W-1:0] rd;
  } op_tag_t;

  // rstatus code for a failed operation, zero-extended to the data width.
  function automatic logic [DATA_W-1:0] exc_code(input logic            is_div,
                                                 input logic [EXC_W-1:0] mult_exc,
                                                 input logic [EXC_W-1:0] div_exc);
    return DATA_W'(is_div ? div_exc : mult_exc);
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Controller <-> multdiv handshake bus.
//   master (controller): drives operands and one-cycle start pulses
//   slave  (multdiv)   : returns result, exception and ready
interface multdiv_ctrl_if;
  import multdiv_ctrl_pkg::*;

  logic [DATA_W-1:0] md_operandA;
  logic [DATA_W-1:0] md_operandB;
  logic              md_ctrl_MULT;
  logic              md_ctrl_DIV;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_resultRDY;

  modport master (
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  md_result, md_exception, md_resultRDY
  );

  modport slave (
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output md_result, md_exception, md_resultRDY
  );
endinterface

// File: rtl/mdc_watchdog.sv
// Watchdog for the BUSY phase: 6-bit up-counter with synchronous clear
// and a terminal compare against TIMEOUT.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : increment
//   expired_c  : count equals TIMEOUT (combinational)
module mdc_watchdog
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [CNT_W-1:0] count;

  // Cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller sequencing the iterative multdiv unit.
// Captures a mult/div issue, pulses the unit's start, stalls the pipeline
// until ready or watchdog expiry, then emits one registered writeback beat.
//   clock, reset_n          : clock, async active-low reset
//   issue_*                 : mult/div instruction from execute
//   flush                   : squash the in-flight operation
//   md                      : multdiv bus (master side)
//   stall                   : pipeline freeze (combinational)
//   wb_valid/wb_rd/wb_data  : one-cycle writeback beat
//   busy                    : controller not idle
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned STATUS_REG = DEF_STATUS_REG,
  parameter int unsigned MULT_EXC   = DEF_MULT_EXC,
  parameter int unsigned DIV_EXC    = DEF_DIV_EXC
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [DATA_W-1:0] issue_opA,
  input  logic [DATA_W-1:0] issue_opB,
  input  logic [RD_W-1:0]   issue_rd,
  input  logic              flush,
  multdiv_ctrl_if.master    md,
  output logic              stall,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  state_e  state;
  op_tag_t tag_q;
  logic    drop;

  logic in_run_c;
  logic wd_clr_c;
  logic wd_en_c;
  logic expired_c;
  logic done_go_c;
  logic done_exc_c;
  logic accept_c;

  assign in_run_c   = (state == ST_START) || (state == ST_BUSY);
  assign wd_clr_c   = (state == ST_START);
  assign wd_en_c    = (state == ST_BUSY);
  assign accept_c   = (state == ST_IDLE) && issue_valid && !flush;
  // Ready wins over a coincident watchdog expiry.
  assign done_go_c  = (state == ST_BUSY) && (md.md_resultRDY || expired_c);
  assign done_exc_c = md.md_resultRDY ? md.md_exception : 1'b1;

  mdc_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clock),
    .rst_n     (reset_n),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .expired_c (expired_c)
  );

  // Stall: hold the issuing instruction, hold execute while a live op runs,
  // and hold a new issue while a dropped op drains.
  assign stall = accept_c
               | (in_run_c && !drop && !flush)
               | ((state != ST_IDLE) && drop && issue_valid && !flush);

  // Sequencer, capture registers and writeback mux.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      tag_q           <= '0;
      drop            <= 1'b0;
      md.md_operandA  <= '0;
      md.md_operandB  <= '0;
      md.md_ctrl_MULT <= 1'b0;
      md.md_ctrl_DIV  <= 1'b0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      busy            <= 1'b0;
    end else begin
      md.md_ctrl_MULT <= 1'b0;
      md.md_ctrl_DIV  <= 1'b0;
      wb_valid        <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept_c) begin
            md.md_operandA  <= issue_opA;
            md.md_operandB  <= issue_opB;
            md.md_ctrl_MULT <= !issue_is_div;
            md.md_ctrl_DIV  <= issue_is_div;
            tag_q.is_div    <= issue_is_div;
            tag_q.rd        <= issue_rd;
            drop            <= 1'b0;
            busy            <= 1'b1;
            state           <= ST_START;
          end
        end
        ST_START: begin
          // Ready is ignored here: it may still be high from the last op.
          if (flush) drop <= 1'b1;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (flush) drop <= 1'b1;
          if (done_go_c) begin
            wb_valid <= !(drop || flush) && (done_exc_c || (tag_q.rd != '0));
            wb_rd    <= done_exc_c ? RD_W'(STATUS_REG) : tag_q.rd;
            wb_data  <= done_exc_c ? exc_code(tag_q.is_div, EXC_W'(MULT_EXC), EXC_W'(DIV_EXC))
                                   : md.md_result;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The beat is already registered; a flush here only marks drop.
          if (flush) drop <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl.
module tb_multdiv_ctrl;
  import multdiv_ctrl_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_is_div;
  logic [31:0] issue_opA;
  logic [31:0] issue_opB;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  multdiv_ctrl_if md_bus ();

  multdiv_ctrl #(.TIMEOUT(40)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_is_div (issue_is_div),
    .issue_opA    (issue_opA),
    .issue_opB    (issue_opB),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .md           (md_bus),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Runs one op to retirement, acting as pipeline and as the multdiv model.
  // lat < 0: ready never comes. stale: ready held high before/into START.
  task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int lat, input logic exc,
                        input logic [31:0] res, input logic stale,
                        output int n_stall, output int n_mul, output int n_div,
                        output int n_wb, output int d_wb, output logic [4:0] o_rd,
                        output logic [31:0] o_data, output logic [31:0] o_opa,
                        output logic done);
    int   since;
    int   t_start;
    logic started;
    logic adv;
    logic hit;
    n_stall = 0; n_mul = 0; n_div = 0; n_wb = 0; d_wb = -1;
    o_rd = '0; o_data = '0; o_opa = '0; done = 1'b0;
    since = 0; t_start = 0; started = 1'b0; adv = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      cyc();
      if (c == 0) begin
        issue_valid = 1'b1; issue_is_div = div; issue_opA = a; issue_opB = b; issue_rd = r;
      end
      if (adv) issue_valid = 1'b0;
      if (started) since++;
      hit = started && (lat >= 0) && (since == lat);
      md_bus.md_resultRDY = hit || (stale && !started);
      md_bus.md_exception = hit ? exc : 1'b0;
      md_bus.md_result    = hit ? res : 32'hDEAD_BEEF;
      #1;
      if (stall) n_stall++;
      if (md_bus.md_ctrl_MULT) n_mul++;
      if (md_bus.md_ctrl_DIV) n_div++;
      if (!started && (md_bus.md_ctrl_MULT || md_bus.md_ctrl_DIV)) begin
        started = 1'b1; since = 0; t_start = c; o_opa = md_bus.md_operandA;
      end
      if (wb_valid) begin
        n_wb++; o_rd = wb_rd; o_data = wb_data; d_wb = c - t_start;
      end
      adv = issue_valid && !stall;
      if (started && !busy && !issue_valid) done = 1'b1;
    end
    md_bus.md_resultRDY = 1'b0;
    md_bus.md_exception = 1'b0;
    issue_valid = 1'b0;
  endtask

  int          n_stall, n_mul, n_div, n_wb, d_wb;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_opa;
  logic        done;

  initial begin
    reset_n = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0;
    issue_opA = '0; issue_opB = '0; issue_rd = '0; flush = 1'b0;
    md_bus.md_result = '0; md_bus.md_exception = 1'b0; md_bus.md_resultRDY = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_opA", md_bus.md_operandA, 0);
    chk("rst_opB", md_bus.md_operandB, 0);
    chk("rst_mult", 32'(md_bus.md_ctrl_MULT), 0);
    chk("rst_div", 32'(md_bus.md_ctrl_DIV), 0);
    reset_n = 1'b1;

    // Mult 7x6, rd=3, ready 33 cycles after START.
    run_op(1'b0, 32'd7, 32'd6, 5'd3, 33, 1'b0, 32'd42, 1'b0,
           n_stall, n_mul, n_div, n_wb, d_wb, o_rd, o_data, o_opa, done);
    chk("mul_done", 32'(done), 1);
    chk("mul_pulse", 32'(n_mul), 1);
    chk("mul_nodiv", 32'(n_div), 0);
    chk("mul_stall_cycles", 32'(n_stall), 35);
    chk("mul_opA", o_opa, 7);
    chk("mul_wb_beats", 32'(n_wb), 1);
    chk("mul_wb_rd", 32'(o_rd), 3);
    chk("mul_wb_data", o_data, 42);
    chk("mul_wb_delay", 32'(d_wb), 34);

    // Div 100/0 raising exception.
    run_op(1'b1, 32'd100, 32'd0, 5'd8, 10, 1'b1, 32'h0, 1'b0,
           n_stall, n_mul, n_div, n_wb, d_wb, o_rd, o_data, o_opa, done);
    chk("div0_done", 32'(done), 1);
    chk("div0_pulse", 32'(n_div), 1);
    chk("div0_nomul", 32'(n_mul), 0);
    chk("div0_wb_beats", 32'(n_wb), 1);
    chk("div0_wb_rd", 32'(o_rd), 30);
    chk("div0_wb_data", o_data, 5);

    // Stale ready held into START must be ignored.
    run_op(1'b0, 32'd2, 32'd3, 5'd5, 4, 1'b0, 32'h1234, 1'b1,
           n_stall, n_mul, n_div, n_wb, d_wb, o_rd, o_data, o_opa, done);
    chk("stale_done", 32'(done), 1);
    chk("stale_wb_beats", 32'(n_wb), 1);
    chk("stale_wb_delay", 32'(d_wb), 5);
    chk("stale_wb_data", o_data, 32'h1234);

    // Watchdog: ready never arrives.
    run_op(1'b0, 32'd1, 32'd1, 5'd9, -1, 1'b0, 32'h0, 1'b0,
           n_stall, n_mul, n_div, n_wb, d_wb, o_rd, o_data, o_opa, done);
    chk("wdog_done", 32'(done), 1);
    chk("wdog_wb_beats", 32'(n_wb), 1);
    chk("wdog_wb_rd", 32'(o_rd), 30);
    chk("wdog_wb_data", o_data, 4);
    chk("wdog_wb_delay", 32'(d_wb), 42);
    chk("wdog_idle", 32'(busy), 0);

    // Flush mid-BUSY with the next issue waiting behind it.
    cyc();
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_opA = 32'd3; issue_opB = 32'd5; issue_rd = 5'd4;
    #1; chk("fl_accept_stall", 32'(stall), 1);
    cyc(); #1;
    chk("fl_start_pulse", 32'(md_bus.md_ctrl_MULT), 1);
    chk("fl_start_opA", md_bus.md_operandA, 3);
    chk("fl_start_busy", 32'(busy), 1);
    cyc(); #1; chk("fl_busy_stall", 32'(stall), 1);
    cyc();
    flush = 1'b1; issue_valid = 1'b0;
    #1; chk("fl_flush_stall", 32'(stall), 0);
    cyc();
    flush = 1'b0; issue_valid = 1'b1; issue_opA = 32'd9; issue_opB = 32'd9; issue_rd = 5'd6;
    #1;
    chk("fl_wait_stall", 32'(stall), 1);
    chk("fl_wait_busy", 32'(busy), 1);
    cyc();
    md_bus.md_resultRDY = 1'b1; md_bus.md_result = 32'd15;
    #1;
    chk("fl_rdy_stall", 32'(stall), 1);
    chk("fl_opA_held", md_bus.md_operandA, 3);
    cyc();
    md_bus.md_resultRDY = 1'b0;
    #1;
    chk("fl_done_no_wb", 32'(wb_valid), 0);
    chk("fl_done_stall", 32'(stall), 1);
    cyc(); #1;
    chk("fl_idle_busy", 32'(busy), 0);
    chk("fl_idle_stall", 32'(stall), 1);
    cyc(); #1;
    chk("fl_new_pulse", 32'(md_bus.md_ctrl_MULT), 1);
    chk("fl_new_opA", md_bus.md_operandA, 9);
    chk("fl_new_stall", 32'(stall), 1);
    cyc();
    md_bus.md_resultRDY = 1'b1; md_bus.md_result = 32'd81;
    #1; chk("fl_new_busy_stall", 32'(stall), 1);
    cyc();
    md_bus.md_resultRDY = 1'b0;
    #1;
    chk("fl_new_wb_valid", 32'(wb_valid), 1);
    chk("fl_new_wb_rd", 32'(wb_rd), 6);
    chk("fl_new_wb_data", wb_data, 81);
    chk("fl_new_done_stall", 32'(stall), 0);
    cyc();
    issue_valid = 1'b0;
    #1;
    chk("fl_end_wb_valid", 32'(wb_valid), 0);
    chk("fl_end_busy", 32'(busy), 0);

    // Mult with rd=0 and no exception: no beat.
    run_op(1'b0, 32'd4, 32'd4, 5'd0, 6, 1'b0, 32'd16, 1'b0,
           n_stall, n_mul, n_div, n_wb, d_wb, o_rd, o_data, o_opa, done);
    chk("rd0_done", 32'(done), 1);
    chk("rd0_wb_beats", 32'(n_wb), 0);
    chk("rd0_stall_cycles", 32'(n_stall), 8);

    // Reset asserted mid-BUSY.
    cyc();
    issue_valid = 1'b1; issue_is_div = 1'b1; issue_opA = 32'd50; issue_opB = 32'd7; issue_rd = 5'd2;
    cyc(); #1;
    chk("rm_div_pulse", 32'(md_bus.md_ctrl_DIV), 1);
    cyc();
    cyc();
    reset_n = 1'b0; issue_valid = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_stall", 32'(stall), 0);
    chk("rm_opA", md_bus.md_operandA, 0);
    chk("rm_opB", md_bus.md_operandB, 0);
    chk("rm_wb_valid", 32'(wb_valid), 0);
    chk("rm_wb_data", wb_data, 0);
    #3;
    reset_n = 1'b1;
    md_bus.md_resultRDY = 1'b1; md_bus.md_result = 32'd7;
    cyc(); #1;
    chk("rm_post_wb", 32'(wb_valid), 0);
    chk("rm_post_busy", 32'(busy), 0);
    cyc(); #1;
    chk("rm_post_wb2", 32'(wb_valid), 0);
    md_bus.md_resultRDY = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
